// File: rtl/seq_detect_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_pkg
//
// Shared definitions for the parametrised serial pattern detector.
//   MAX_LEN_LIMIT : largest pattern length the detector family supports
//   OVERLAP       : detection mode where bits may be shared between matches
//   NONOVERLAP    : detection mode where a match consumes its bits
//   clamp_len()   : limits a requested pattern length to the hardware maximum
// ---------------------------------------------------------------------------
package seq_detect_pkg;

    localparam int MAX_LEN_LIMIT = 32;

    localparam logic OVERLAP    = 1'b1;
    localparam logic NONOVERLAP = 1'b0;

    // A requested length above what the history can hold is treated as the
    // longest pattern the instance can check, rather than being rejected.
    function automatic int clamp_len(input int req_len, input int max_len);
        return (req_len > max_len) ? max_len : req_len;
    endfunction

endpackage

// File: rtl/seq_shift_hist.sv
// ---------------------------------------------------------------------------
// seq_shift_hist
//
// Serial history shift register plus fill counter for the pattern detector.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   shift_en   : accept bit_in this cycle (shift history, advance fill)
//   flush      : clear history and fill (takes priority over shift_en)
//   fill_clr   : on a shifting cycle, restart fill from zero instead of
//                advancing it (used for non-overlapping detection)
//   bit_in     : incoming serial bit
//   window     : look-ahead compare window, previous bits with bit_in as
//                the newest bit in position [0]
//   fill       : number of accepted bits since the last flush, 0..MAX_LEN
// ---------------------------------------------------------------------------
module seq_shift_hist
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_en,
    input  logic               flush,
    input  logic               fill_clr,
    input  logic               bit_in,
    output logic [MAX_LEN-1:0] window,
    output logic [LEN_W-1:0]   fill
);

    // Only MAX_LEN-1 past bits are stored: the compare window always takes
    // the incoming bit as its newest position, so the oldest bit of a full
    // MAX_LEN history could never take part in a comparison.
    logic [MAX_LEN-2:0] hist;

    assign window = {hist, bit_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else if (flush) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= window[MAX_LEN-2:0];
            if (fill_clr) begin
                fill <= '0;
            end else if (fill != LEN_W'(MAX_LEN)) begin
                fill <= fill + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//
// Run-time configurable serial bit-pattern detector. One bit is sampled per
// in_valid cycle; w pulses for one cycle when the newest act_len bits equal
// the programmed pattern (pattern[len-1] oldest, pattern[0] newest).
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   in_valid, a  : qualified serial data bit
//   cfg_load     : latch cfg_pattern / cfg_len / cfg_overlap and flush history
//   cfg_pattern  : pattern to match
//   cfg_len      : pattern length (clamped to MAX_LEN, 0 disables detection)
//   cfg_overlap  : 1 = overlapping detection, 0 = non-overlapping
//   cnt_clr      : synchronous clear of match_cnt (wins over an increment)
//   w            : registered one-cycle match pulse
//   match_cnt    : saturating count of matches
//   act_len      : currently active (clamped) pattern length
// ---------------------------------------------------------------------------
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               MAX_LEN     = 8,
    parameter int               CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_0101,
    parameter int               RST_LEN     = 3,
    parameter int               LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               a,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               w,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [LEN_W-1:0]   act_len
);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ov_q;

    logic [MAX_LEN-1:0] window;
    logic [LEN_W-1:0]   fill;
    logic               shift_en;
    logic               match;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_plus;

    // A configuration load owns its cycle: any coincident data bit is dropped.
    assign shift_en = in_valid & ~cfg_load;

    seq_shift_hist #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .flush    (cfg_load),
        .fill_clr (match & (ov_q == NONOVERLAP)),
        .bit_in   (a),
        .window   (window),
        .fill     (fill)
    );

    // Active configuration registers; the new values apply from the first
    // valid bit after the load edge because the history is flushed as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= RST_PATTERN;
            len_q <= LEN_W'(clamp_len(RST_LEN, MAX_LEN));
            ov_q  <= OVERLAP;
        end else if (cfg_load) begin
            pat_q <= cfg_pattern;
            len_q <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
            ov_q  <= cfg_overlap;
        end
    end

    // Match evaluation on the window as it will look after this bit. Only the
    // low len_q positions take part; fill+1 counts the incoming bit so that a
    // freshly flushed history cannot match on stale zeros.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_q)) begin
                len_mask[i] = 1'b1;
            end
        end
        fill_plus = {1'b0, fill} + (LEN_W + 1)'(1);
        match = shift_en
              && (len_q != '0)
              && (fill_plus >= {1'b0, len_q})
              && (((window ^ pat_q) & len_mask) == '0);
    end

    // Registered match pulse and saturating counter; a clear beats an
    // increment on the same edge but the pulse itself still appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w         <= 1'b0;
            match_cnt <= '0;
        end else begin
            w <= match;
            if (cnt_clr) begin
                match_cnt <= '0;
            end else if (match && (match_cnt != '1)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

    assign act_len = len_q;

endmodule
